// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush/memory-arbitration controller for the 5-stage pipeline.
// Optional performance counters are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEX_MemRead,
  input  logic [3:0]  IDEX_WReg,
  input  logic [3:0]  IFID_RegA,
  input  logic [3:0]  IFID_RegB,
  input  logic        IFID_UsesA,
  input  logic        IFID_UsesB,
  input  logic        branch_taken,
  input  logic        halt_ID,
  input  logic        halt_WB,
  input  logic        icache_miss,
  input  logic        dcache_miss,
  input  logic        mem_fill_done,
  output logic        PC_WE,
  output logic        IFID_WE,
  output logic        IDEX_WE,
  output logic        EXMEM_WE,
  output logic        MEMWB_WE,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        mem_grant_i,
  output logic        mem_grant_d,
  output logic        halted
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [15:0] dstall_cnt,
  output logic [15:0] istall_cnt,
  output logic [15:0] hazard_cnt
`endif
);

  typedef enum logic [1:0] {RUN, IFILL, DFILL, HALTED} state_t;

  state_t state_q, state_d;
  logic   halt_pending_q, halt_pending_d;
  logic   frozen;
  logic   load_use;
  logic   lu_stall;

  assign frozen = (state_q == DFILL) || ((state_q == IFILL) && dcache_miss) ||
                  (state_q == HALTED);

  assign load_use = IDEX_MemRead && (IDEX_WReg != '0) &&
                    ((IFID_UsesA && (IFID_RegA == IDEX_WReg)) ||
                     (IFID_UsesB && (IFID_RegB == IDEX_WReg)));

  assign lu_stall = load_use && !frozen && !rst;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (dcache_miss)      state_d = DFILL;
        else if (icache_miss) state_d = IFILL;
      end
      IFILL: begin
        // A D miss raised during the I fill is queued behind it, no RUN gap.
        if (mem_fill_done) state_d = dcache_miss ? DFILL : RUN;
      end
      DFILL: begin
        if (mem_fill_done) state_d = RUN;
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (halt_WB && (state_q != HALTED)) state_d = HALTED;
  end

  assign halt_pending_d = halt_pending_q || (halt_ID && !frozen);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      halt_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
    end
  end

  always_comb begin
    PC_WE      = 1'b1;
    IFID_WE    = 1'b1;
    IDEX_WE    = 1'b1;
    EXMEM_WE   = 1'b1;
    MEMWB_WE   = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    if (rst) begin
      // Reset keeps every stage loading so the pipeline registers clear.
    end else if (frozen) begin
      PC_WE    = 1'b0;
      IFID_WE  = 1'b0;
      IDEX_WE  = 1'b0;
      EXMEM_WE = 1'b0;
      MEMWB_WE = 1'b0;
    end else if (load_use) begin
      PC_WE      = 1'b0;
      IFID_WE    = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (branch_taken) begin
      IFID_Flush = 1'b1;
    end else if ((state_q == IFILL) || halt_pending_q) begin
      PC_WE      = 1'b0;
      IFID_Flush = 1'b1;
    end
  end

  assign mem_grant_i = !rst && (state_q == IFILL);
  assign mem_grant_d = !rst && (state_q == DFILL);
  assign halted      = (state_q == HALTED);

`ifdef STALL_PERF_CNT_EN
  logic [15:0] dstall_q, dstall_d;
  logic [15:0] istall_q, istall_d;
  logic [15:0] hazard_q, hazard_d;

  always_comb begin
    dstall_d = dstall_q;
    istall_d = istall_q;
    hazard_d = hazard_q;
    if ((state_q == DFILL) && (dstall_q != '1)) dstall_d = dstall_q + 16'd1;
    if ((state_q == IFILL) && (istall_q != '1)) istall_d = istall_q + 16'd1;
    if (lu_stall && (hazard_q != '1))           hazard_d = hazard_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dstall_q <= '0;
      istall_q <= '0;
      hazard_q <= '0;
    end else begin
      dstall_q <= dstall_d;
      istall_q <= istall_d;
      hazard_q <= hazard_d;
    end
  end

  assign dstall_cnt = dstall_q;
  assign istall_cnt = istall_q;
  assign hazard_cnt = hazard_q;
`else
  logic unused_lu_stall;
  assign unused_lu_stall = lu_stall;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl; output vector is
// {PC,IFID,IDEX,EXMEM,MEMWB WE, IFID/IDEX flush, grant_i, grant_d, halted}.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       IDEX_MemRead;
  logic [3:0] IDEX_WReg, IFID_RegA, IFID_RegB;
  logic       IFID_UsesA, IFID_UsesB;
  logic       branch_taken, halt_ID, halt_WB;
  logic       icache_miss, dcache_miss, mem_fill_done;
  logic       PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE;
  logic       IFID_Flush, IDEX_Flush, mem_grant_i, mem_grant_d, halted;
`ifdef STALL_PERF_CNT_EN
  logic [15:0] dstall_cnt, istall_cnt, hazard_cnt;
`endif

  logic [9:0] outs;
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [9:0] O_RUN   = 10'b11111_00_00_0;
  localparam logic [9:0] O_LU    = 10'b00111_01_00_0;
  localparam logic [9:0] O_BR    = 10'b11111_10_00_0;
  localparam logic [9:0] O_DF    = 10'b00000_00_01_0;
  localparam logic [9:0] O_IF    = 10'b01111_10_10_0;
  localparam logic [9:0] O_IFBR  = 10'b11111_10_10_0;
  localparam logic [9:0] O_IFFRZ = 10'b00000_00_10_0;
  localparam logic [9:0] O_HLTP  = 10'b01111_10_00_0;
  localparam logic [9:0] O_HALT  = 10'b00000_00_00_1;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_WReg(IDEX_WReg),
    .IFID_RegA(IFID_RegA), .IFID_RegB(IFID_RegB),
    .IFID_UsesA(IFID_UsesA), .IFID_UsesB(IFID_UsesB),
    .branch_taken(branch_taken), .halt_ID(halt_ID), .halt_WB(halt_WB),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .mem_fill_done(mem_fill_done),
    .PC_WE(PC_WE), .IFID_WE(IFID_WE), .IDEX_WE(IDEX_WE),
    .EXMEM_WE(EXMEM_WE), .MEMWB_WE(MEMWB_WE),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .mem_grant_i(mem_grant_i), .mem_grant_d(mem_grant_d), .halted(halted)
`ifdef STALL_PERF_CNT_EN
    , .dstall_cnt(dstall_cnt), .istall_cnt(istall_cnt), .hazard_cnt(hazard_cnt)
`endif
  );

  assign outs = {PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE,
                 IFID_Flush, IDEX_Flush, mem_grant_i, mem_grant_d, halted};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    IDEX_MemRead = 0; IDEX_WReg = 0; IFID_RegA = 0; IFID_RegB = 0;
    IFID_UsesA = 0; IFID_UsesB = 0; branch_taken = 0; halt_ID = 0;
    halt_WB = 0; icache_miss = 0; dcache_miss = 0; mem_fill_done = 0;
  endtask

  initial begin
    clr_inputs();
    rst = 1;
    tick();
    // hostile inputs while reset is held
    dcache_miss = 1; icache_miss = 1; branch_taken = 1; halt_WB = 1;
    IDEX_MemRead = 1; IDEX_WReg = 3; IFID_RegA = 3; IFID_UsesA = 1;
    #1 check_eq("rst_outs", 16'(outs), 16'(O_RUN));
    tick();
    rst = 0; clr_inputs();
    #1 check_eq("run_idle", 16'(outs), 16'(O_RUN));

    // load-use via A
    IDEX_MemRead = 1; IDEX_WReg = 3; IFID_RegA = 3; IFID_UsesA = 1;
    #1 check_eq("lu_a", 16'(outs), 16'(O_LU));
    tick();
    IDEX_MemRead = 0;
    #1 check_eq("lu_release", 16'(outs), 16'(O_RUN));
    IDEX_MemRead = 1; IDEX_WReg = 0; IFID_RegA = 0;
    #1 check_eq("lu_r0", 16'(outs), 16'(O_RUN));
    tick();
    IDEX_WReg = 5; IFID_RegA = 5; IFID_UsesA = 0; IFID_RegB = 5; IFID_UsesB = 0;
    #1 check_eq("lu_unused", 16'(outs), 16'(O_RUN));
    IFID_UsesB = 1;
    #1 check_eq("lu_b", 16'(outs), 16'(O_LU));
    tick();
    IDEX_MemRead = 0; IFID_UsesB = 0; branch_taken = 1;
    #1 check_eq("branch", 16'(outs), 16'(O_BR));
    IDEX_MemRead = 1; IFID_UsesB = 1;
    #1 check_eq("branch_lu", 16'(outs), 16'(O_LU));
    tick();
    clr_inputs();
    #1 check_eq("run_after_br", 16'(outs), 16'(O_RUN));
`ifdef STALL_PERF_CNT_EN
    check_eq("hazard_cnt", hazard_cnt, 16'd3);
`endif

    // simultaneous misses: D first, then I after one RUN cycle
    icache_miss = 1; dcache_miss = 1;
    #1 check_eq("miss_seen", 16'(outs), 16'(O_RUN));
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      mem_fill_done = (i == 3);
      #1 check_eq("dfill", 16'(outs), 16'(O_DF));
    end
    tick();
    mem_fill_done = 0; dcache_miss = 0;
    #1 check_eq("gap_run", 16'(outs), 16'(O_RUN));
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      mem_fill_done = (i == 3);
      #1 check_eq("ifill", 16'(outs), 16'(O_IF));
    end
    tick();
    mem_fill_done = 0; icache_miss = 0;
    #1 check_eq("ifill_done", 16'(outs), 16'(O_RUN));
`ifdef STALL_PERF_CNT_EN
    check_eq("dstall_cnt", dstall_cnt, 16'd4);
    check_eq("istall_cnt", istall_cnt, 16'd4);
`endif

    // fill-done with no grant is ignored
    mem_fill_done = 1;
    tick();
    mem_fill_done = 0;
    #1 check_eq("stray_done", 16'(outs), 16'(O_RUN));

    // IFILL with branch, then D miss queued behind the I fill
    icache_miss = 1;
    tick();
    #1 check_eq("ifill2", 16'(outs), 16'(O_IF));
    branch_taken = 1;
    #1 check_eq("ifill_branch", 16'(outs), 16'(O_IFBR));
    tick();
    branch_taken = 0; dcache_miss = 1;
    #1 check_eq("ifill_dmiss", 16'(outs), 16'(O_IFFRZ));
    mem_fill_done = 1;
    tick();
    mem_fill_done = 0; icache_miss = 0;
    #1 check_eq("i_to_d", 16'(outs), 16'(O_DF));
    mem_fill_done = 1;
    tick();
    mem_fill_done = 0; dcache_miss = 0;
    #1 check_eq("d_done", 16'(outs), 16'(O_RUN));

    // halt drain
    halt_ID = 1;
    #1 check_eq("halt_id", 16'(outs), 16'(O_RUN));
    tick();
    halt_ID = 0;
    #1 check_eq("halt_pend1", 16'(outs), 16'(O_HLTP));
    tick();
    #1 check_eq("halt_pend2", 16'(outs), 16'(O_HLTP));
    tick();
    halt_WB = 1;
    #1 check_eq("halt_pend3", 16'(outs), 16'(O_HLTP));
    tick();
    halt_WB = 0; icache_miss = 1; dcache_miss = 1;
    IDEX_MemRead = 1; IDEX_WReg = 2; IFID_RegA = 2; IFID_UsesA = 1;
    #1 check_eq("halted", 16'(outs), 16'(O_HALT));
    tick();
    #1 check_eq("halted_hold", 16'(outs), 16'(O_HALT));
`ifdef STALL_PERF_CNT_EN
    check_eq("hazard_frozen", hazard_cnt, 16'd3);
    check_eq("dstall_frozen", dstall_cnt, 16'd5);
    check_eq("istall_frozen", istall_cnt, 16'd6);
`endif
    rst = 1;
    tick();
    rst = 0; clr_inputs();
    #1 check_eq("post_halt_rst", 16'(outs), 16'(O_RUN));

    // reset in the middle of a D fill
    dcache_miss = 1;
    tick();
    #1 check_eq("dfill3", 16'(outs), 16'(O_DF));
    rst = 1;
    #1 check_eq("rst_in_dfill", 16'(outs), 16'(O_RUN));
    tick();
    rst = 0; dcache_miss = 0;
    #1 check_eq("after_rst", 16'(outs), 16'(O_RUN));
`ifdef STALL_PERF_CNT_EN
    check_eq("dstall_rst", dstall_cnt, 16'd0);
    check_eq("istall_rst", istall_cnt, 16'd0);
    check_eq("hazard_rst", hazard_cnt, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall, flush and memory-arbitration controller for the 5-stage pipeline. Drives the `WriteEnable` and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Arbitrates the single shared main-memory fill port between I-cache and D-cache misses. Detects load-use hazards and sequences the halt drain until the halt bit leaves MEM/WB.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `IDEX_MemRead` input 1: instruction in ID/EX is a load.
- `IDEX_WReg` input 4: load destination register.
- `IFID_RegA`, `IFID_RegB` input 4 each: source registers of the instruction in ID.
- `IFID_UsesA`, `IFID_UsesB` input 1 each: source is actually read.
- `branch_taken` input 1: branch in ID resolved taken.
- `halt_ID` input 1: HLT decoded in ID.
- `halt_WB` input 1: halt bit at MEM/WB output.
- `icache_miss`, `dcache_miss` input 1 each: level requests, held until the fill completes.
- `mem_fill_done` input 1: one-cycle pulse, granted fill finished.
- `PC_WE`, `IFID_WE`, `IDEX_WE`, `EXMEM_WE`, `MEMWB_WE` output 1 each: register write enables.
- `IFID_Flush`, `IDEX_Flush` output 1 each: load a NOP bubble on the next edge when the matching WE=1.
- `mem_grant_i`, `mem_grant_d` output 1 each: memory port owner, one-hot or zero.
- `halted` output 1: processor stopped.

## Operation
- States: RUN, IFILL, DFILL, HALTED. The state register and `halt_pending` flag are registered. All other outputs are combinational from state, flags and inputs.
- `frozen` = (state==DFILL) or (state==IFILL and `dcache_miss`) or (state==HALTED).
- `frozen`: all five WE=0, both flushes=0.
- `load_use` = `IDEX_MemRead` & `IDEX_WReg`!=0 & ((`IFID_UsesA` & RegA==`IDEX_WReg`) | (`IFID_UsesB` & RegB==`IDEX_WReg`)).
- Not frozen, priority high to low:
  - `load_use`: `PC_WE`=0, `IFID_WE`=0, `IDEX_Flush`=1, downstream WE=1.
  - `branch_taken`: `PC_WE`=1, `IFID_Flush`=1.
  - State IFILL or `halt_pending`: `PC_WE`=0, `IFID_Flush`=1.
  - Otherwise: all WE=1, flushes=0.
- Transitions:
  - RUN → DFILL on `dcache_miss`; D wins when both misses are asserted.
  - RUN → IFILL on `icache_miss` alone.
  - DFILL → RUN on `mem_fill_done`.
  - IFILL → DFILL on `mem_fill_done` with `dcache_miss` high; otherwise IFILL → RUN on `mem_fill_done`.
  - Any non-HALTED state → HALTED on `halt_WB`; takes priority over all other transitions.
- A fill in progress is never preempted. A D miss raised during IFILL freezes the pipeline but waits for the I fill to finish.
- `mem_grant_i`=1 iff state==IFILL; `mem_grant_d`=1 iff state==DFILL.
- `halt_pending` sets when `halt_ID` is high and not frozen. Cleared only by `rst`.
- `branch_taken` during IFILL still redirects the PC. The fill runs to completion.
- HALTED is left only by `rst`; `halted`=1 in HALTED.

## Timing
- Reset (`rst` high at a rising edge): state=RUN, `halt_pending`=0, `halted`=0, grants=0.
- While `rst` is high: all WE=1, flushes=0, grants=0, regardless of other inputs.
- A miss seen in RUN produces its grant the cycle after it is seen.
- Freeze/stall WEs respond in the same cycle as the causing input.
- `mem_fill_done` in cycle N: state changes at the edge ending N. In cycle N+1 the grant is dropped, or switched to D.
- `mem_fill_done` while no grant is active is ignored.
- Load-use stall lasts exactly one cycle, because ID/EX receives a bubble.
- `halted` rises the cycle after `halt_WB` is seen.

## Configuration
- `STALL_PERF_CNT_EN` defined: adds outputs `dstall_cnt`, `istall_cnt` and `hazard_cnt`, 16 bits each.
  - `dstall_cnt` increments each DFILL cycle.
  - `istall_cnt` increments each IFILL cycle.
  - `hazard_cnt` increments each `load_use` stall cycle.
  - All three saturate at 0xFFFF, reset to 0, and freeze in HALTED.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Load R3 in EX, ID reads R3 via A (`IFID_UsesA`=1) → one cycle with `PC_WE`=0, `IFID_WE`=0, `IDEX_Flush`=1; next cycle all WE=1. Same case with `IDEX_WReg`=0 → no stall.
- `icache_miss` and `dcache_miss` rise together; fill latency 4 cycles each → DFILL for 4 cycles (all WE=0, `mem_grant_d`=1), then IFILL for 4 cycles (`PC_WE`=0, `IFID_Flush`=1, `mem_grant_i`=1), then RUN.
- During IFILL, `dcache_miss` rises → all WE=0 immediately. `mem_fill_done` → DFILL next cycle with no RUN cycle between.
- `branch_taken` with no stall → `PC_WE`=1, `IFID_Flush`=1 for one cycle. `branch_taken` together with `load_use` → load-use outputs win.
- `halt_ID` pulse, then `halt_WB` 3 cycles later → `PC_WE`=0 and `IFID_Flush`=1 from the cycle after the pulse; `halted`=1 the cycle after `halt_WB`; all WE=0 after. `rst` → RUN, `halted`=0.
- `rst` asserted mid-DFILL → next cycle state=RUN, grants=0, all WE=1. With `STALL_PERF_CNT_EN`, counters read 0.
